bus_core_port: RTL

BUS_CORE_PORT -- requirements
Module: bus_core_port

---
 rtl/bus_core_port_if.sv | 43 ++++
 rtl/bus_core_port.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bus_core_port_if.sv
// rtl/bus_core_port_if.sv - core request/response and bus-arbiter signal bundle
// slave is the port-core side; master is the core plus arbiter environment.
interface bus_core_port_if;
  logic        c_req;
  logic [1:0]  c_kind;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [2:0]  c_ctrl;
  logic        c_ready;
  logic        c_rsp_valid;
  logic [31:0] c_rsp_data;
  logic        c_err;

  logic        bus_dram_le;
  logic        bus_dram_we_t;
  logic        bus_data_le;
  logic        bus_data_we;
  logic [31:0] bus_dram_addr;
  logic [31:0] bus_mem_paddr;
  logic [31:0] bus_dram_wdata;
  logic [31:0] bus_data_wdata;
  logic [2:0]  bus_dram_ctrl;
  logic        bus_dram_busy;
  logic [3:0]  bus_data_busy;
  logic [31:0] bus_dram_odata;
  logic [31:0] bus_data_data;

  modport slave (
    input  c_req, c_kind, c_addr, c_wdata, c_ctrl,
    output c_ready, c_rsp_valid, c_rsp_data, c_err,
    output bus_dram_le, bus_dram_we_t, bus_data_le, bus_data_we,
    output bus_dram_addr, bus_mem_paddr, bus_dram_wdata, bus_data_wdata, bus_dram_ctrl,
    input  bus_dram_busy, bus_data_busy, bus_dram_odata, bus_data_data
  );

  modport master (
    output c_req, c_kind, c_addr, c_wdata, c_ctrl,
    input  c_ready, c_rsp_valid, c_rsp_data, c_err,
    input  bus_dram_le, bus_dram_we_t, bus_data_le, bus_data_we,
    input  bus_dram_addr, bus_mem_paddr, bus_dram_wdata, bus_data_wdata, bus_dram_ctrl,
    output bus_dram_busy, bus_data_busy, bus_dram_odata, bus_data_data
  );
endinterface

// File: rtl/bus_core_port.sv
// rtl/bus_core_port.sv - single-entry request buffer feeding a one-transaction bus port
// Requests park in the buffer, then run ISSUE/WACK/WDONE from an active copy.
module bus_core_port #(
  parameter int ACK_TO = 16
) (
  input  logic          CLK,
  input  logic          RST_X,
  bus_core_port_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WACK, WDONE} state_t;

  localparam logic [7:0] ACK_LIM = 8'(ACK_TO - 1);

  state_t      state, state_nxt;

  logic        buf_valid;
  logic [1:0]  buf_kind;
  logic [31:0] buf_addr;
  logic [31:0] buf_wdata;
  logic [2:0]  buf_ctrl;

  logic [1:0]  act_kind;
  logic [31:0] act_addr;
  logic [31:0] act_wdata;
  logic [2:0]  act_ctrl;

  logic [7:0]  cnt, cnt_nxt;
  logic [3:0]  strobe, strobe_nxt;
  logic        rsp_valid, rsp_valid_nxt;
  logic        rsp_err, rsp_err_nxt;
  logic [31:0] rsp_data, rsp_data_nxt;
  logic        load;
  logic        sel_busy;

  // Kinds 2/3 target the data arbiter, whose busy is a per-requester vector.
  assign sel_busy = act_kind[1] ? (|bus.bus_data_busy) : bus.bus_dram_busy;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    load          = 1'b0;
    strobe_nxt    = 4'b0000;
    cnt_nxt       = cnt;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_data_nxt  = rsp_data;
    case (state)
      IDLE: begin
        if (buf_valid) begin
          load       = 1'b1;
          strobe_nxt = 4'b0001 << buf_kind;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = 8'd0;
        state_nxt = WACK;
      end
      WACK: begin
        if (sel_busy) begin
          state_nxt = WDONE;
        end else begin
          cnt_nxt = cnt + 8'd1;
          if (cnt == ACK_LIM) begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_data_nxt  = 32'd0;
            state_nxt     = IDLE;
          end
        end
      end
      WDONE: begin
        if (!sel_busy) begin
          rsp_valid_nxt = 1'b1;
          case (act_kind)
            2'd0:    rsp_data_nxt = bus.bus_dram_odata;
            2'd2:    rsp_data_nxt = bus.bus_data_data;
            default: rsp_data_nxt = 32'd0;
          endcase
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      buf_valid <= 1'b0;
      buf_kind  <= 2'd0;
      buf_addr  <= 32'd0;
      buf_wdata <= 32'd0;
      buf_ctrl  <= 3'd0;
      act_kind  <= 2'd0;
      act_addr  <= 32'd0;
      act_wdata <= 32'd0;
      act_ctrl  <= 3'd0;
      cnt       <= 8'd0;
      strobe    <= 4'b0000;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= 32'd0;
    end else begin
      // Load and accept are exclusive: load needs a full buffer, accept an empty one.
      if (load) begin
        buf_valid <= 1'b0;
        act_kind  <= buf_kind;
        act_addr  <= buf_addr;
        act_wdata <= buf_wdata;
        act_ctrl  <= buf_ctrl;
      end else if (bus.c_req && !buf_valid) begin
        buf_valid <= 1'b1;
        buf_kind  <= bus.c_kind;
        buf_addr  <= bus.c_addr;
        buf_wdata <= bus.c_wdata;
        buf_ctrl  <= bus.c_ctrl;
      end
      cnt       <= cnt_nxt;
      strobe    <= strobe_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_data  <= rsp_data_nxt;
    end
  end

  assign bus.c_ready        = !buf_valid;
  assign bus.c_rsp_valid    = rsp_valid;
  assign bus.c_err          = rsp_err;
  assign bus.c_rsp_data     = rsp_data;

  assign bus.bus_dram_le    = strobe[0];
  assign bus.bus_dram_we_t  = strobe[1];
  assign bus.bus_data_le    = strobe[2];
  assign bus.bus_data_we    = strobe[3];

  assign bus.bus_dram_addr  = act_addr;
  assign bus.bus_mem_paddr  = act_addr;
  assign bus.bus_dram_wdata = act_wdata;
  assign bus.bus_data_wdata = act_wdata;
  assign bus.bus_dram_ctrl  = act_ctrl;

  a_rsp_single: assert property (@(posedge CLK) disable iff (!RST_X)
    rsp_valid |=> !rsp_valid);
  a_strobe_single: assert property (@(posedge CLK) disable iff (!RST_X)
    (|strobe) |=> !(|strobe));
  a_strobe_onehot: assert property (@(posedge CLK) disable iff (!RST_X)
    $onehot0(strobe));

endmodule
